rom_load: RTL and testbench
===========================

# rom_load

Parametrised successor to the fixed 8-bit boot ROMs: a synchronous single-read-port ROM of configurable size and data width whose contents can be replaced at run time through a byte-stream loader. The loader packs incoming bytes little-endian into DW-bit words. Sits between the CPU/video address buses and the host-side ROM download channel, so system and character ROMs can be reloaded without resynthesis.

## Interface
- KB, 16, capacity in KiB (total bytes = KB*1024)
- DW, 8, read data width in bits: 8, 16 or 32
- FN, "", init file name (Intel HEX/MIF via ram_init_file); empty means no initialisation
- Derived: NB = DW/8 bytes per word; DEPTH = KB*1024/NB words; AW = $clog2(DEPTH)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears loader state and q, never memory contents
- a  in  AW  read word address
- q  out  DW  read data, registered
- dl_start  in  1  one-cycle pulse: (re)start a load at word 0
- dl_valid  in  1  dl_data holds a byte
- dl_data  in  8  load byte
- dl_end  in  1  one-cycle pulse: end of stream, flush partial word
- dl_ready  out  1  loader accepts a byte this cycle
- dl_busy  out  1  loader in LOAD
- dl_done  out  1  last load completed; held until next dl_start or reset
- dl_words  out  AW+1  words written by current/last load

## Operation
- Reset values: q = all ones, dl_ready = 0, dl_busy = 0, dl_done = 0, dl_words = 0, state IDLE, lane = 0, write pointer wa = 0.
- States: IDLE, LOAD, DONE.
  - IDLE --dl_start--> LOAD; DONE --dl_start--> LOAD (clears dl_done, dl_words, wa, lane, packing register).
  - LOAD: dl_ready = 1, dl_busy = 1. A byte transfers when dl_valid && dl_ready.
  - LOAD --dl_end--> DONE; LOAD --last word written--> DONE.
- Packing: byte k of a word (lane k, 0..NB-1) fills bits [8k+7:8k]. On the lane NB-1 byte, the full word (packing register merged with incoming byte) is written to mem[wa] on that same edge; wa and dl_words increment; lane returns to 0.
- Full: writing word DEPTH-1 ends the load. State goes to DONE, dl_words = DEPTH, wa does not wrap and no further bytes are accepted.
- dl_end with lane > 0: the partial word is written at wa with unfilled lanes = 8'hFF; dl_words increments. A byte transferred in the same cycle is packed first, then the flush applies. dl_end with lane = 0 writes nothing.
- dl_start in LOAD: restarts. Any byte in the same cycle is discarded, and the partial word is discarded unwritten.
- dl_start and dl_end in the same cycle: dl_start wins.
- dl_valid, dl_end outside LOAD: ignored.
- Read: q <= mem[a] every cycle, in all states, including during reset deassertion.
- Read-during-write at the same address: q gets the newly written word (write-first).
- Reset mid-load: state IDLE. Words already written remain in memory. The partial word is lost.

## Timing
- Read latency: 1 clock (a sampled on edge n, q valid after edge n).
- Loaded word visible on q: the write edge when a matches, otherwise the next read.
- dl_ready is registered from state: high from the cycle after dl_start, low from the cycle after the terminating edge.
- dl_done rises on the edge that enters DONE.
- Sustained throughput: 1 byte/clock, no bubbles at word boundaries.

## Configuration
- ROM_LOAD_EN defined: loader present as described.
- ROM_LOAD_EN undefined:
  - Loader logic is not built; the memory is a pure ROM initialised from FN.
  - dl_ready, dl_busy and dl_done are tied 0, dl_words is tied 0, and the dl_* inputs are ignored.
  - Read behaviour and latency are unchanged.

## Test plan
- Reset with KB=1, DW=8, FN empty: q = 8'hFF and all dl_* outputs 0; after release, q = mem[a] one clock after a changes.
- DW=16, dl_start, then bytes 0x34,0x12,0x78,0x56 back-to-back, then dl_end: a=0 -> q=16'h1234, a=1 -> q=16'h5678; dl_words=2, dl_done=1.
- DW=32, 5 bytes 0x01..0x05, then dl_end: word1 = 32'hFFFFFF05, dl_words=2.
- KB=1, DW=8, stream 1100 bytes: dl_done after byte 1024, dl_ready=0 thereafter, dl_words=1024, mem[0] unchanged by bytes 1025+.
- DW=16, a=3 held while lane-1 byte for word 3 (value 16'hBEEF) is accepted: q=16'hBEEF on that edge.
- Reset asserted after 3 words mid-load, then dl_start and a new 1-word load: words 1..2 retain old-load data, dl_words=1.

Source files
------------

// File: rtl/rom_load.sv
// Synchronous single-read-port ROM (KB KiB, DW-bit words) that can be reloaded through a little-endian byte-stream loader when ROM_LOAD_EN is defined.
// Latency: q is registered, 1 clock after a; a loader write is visible on q on its own edge when a matches (write-first).
// Backpressure: dl_ready is high only in LOAD and drops from the cycle after the load ends (dl_end or last word written).
module rom_load #(
    parameter int    KB = 16,
    parameter int    DW = 8,
    parameter string FN = "",
    localparam int   NB    = DW / 8,
    localparam int   DEPTH = KB * 1024 / NB,
    localparam int   AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] a,
    output logic [DW-1:0] q,
    input  logic          dl_start,
    input  logic          dl_valid,
    input  logic [7:0]    dl_data,
    input  logic          dl_end,
    output logic          dl_ready,
    output logic          dl_busy,
    output logic          dl_done,
    output logic [AW:0]   dl_words
);

    // The init file is consumed by the vendor attribute on the array only.
    localparam bit unused_fn = (FN == "");

    (* ram_init_file = FN *) logic [DW-1:0] mem [DEPTH];

    logic          we;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdat;

    always_ff @(posedge clock) begin
        if (we) mem[wadr] <= wdat;
    end

    always_ff @(posedge clock) begin
        if (reset)                 q <= '1;
        else if (we && wadr == a)  q <= wdat;
        else                       q <= mem[a];
    end

`ifdef ROM_LOAD_EN
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam int            LW   = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [LW-1:0] LAST = LW'(NB - 1);
    localparam logic [AW-1:0] TOP  = AW'(DEPTH - 1);

    state_t        state;
    logic [LW-1:0] lane;
    logic [LW-1:0] lane_nx;
    logic [DW-1:0] pack;
    logic [DW-1:0] merged;
    logic [AW-1:0] wa;
    logic          xfer;
    logic          lane_last;
    logic          flush;

    // Unfilled lanes of pack are kept at 8'hFF so a flush can write it as-is.
    always_comb begin
        merged = pack;
        for (int k = 0; k < NB; k++) begin
            if (xfer && lane == LW'(k)) merged[8*k +: 8] = dl_data;
        end
    end

    assign xfer      = (state == LOAD) && dl_valid;
    assign lane_last = xfer && (lane == LAST);
    assign lane_nx   = lane_last ? '0 : (xfer ? lane + 1'b1 : lane);
    assign flush     = dl_end && (lane_nx != '0);
    assign we        = (state == LOAD) && !dl_start && (lane_last || flush);
    assign wadr      = wa;
    assign wdat      = merged;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            lane     <= '0;
            wa       <= '0;
            pack     <= '1;
            dl_ready <= 1'b0;
            dl_busy  <= 1'b0;
            dl_done  <= 1'b0;
            dl_words <= '0;
        end else if (dl_start) begin
            state    <= LOAD;
            lane     <= '0;
            wa       <= '0;
            pack     <= '1;
            dl_ready <= 1'b1;
            dl_busy  <= 1'b1;
            dl_done  <= 1'b0;
            dl_words <= '0;
        end else if (state == LOAD) begin
            lane <= lane_nx;
            pack <= we ? '1 : merged;
            if (we) begin
                dl_words <= dl_words + 1'b1;
                if (wa != TOP) wa <= wa + 1'b1;
            end
            // Writing the top word ends the load; wa never wraps.
            if (dl_end || (we && wa == TOP)) begin
                state    <= DONE;
                dl_ready <= 1'b0;
                dl_busy  <= 1'b0;
                dl_done  <= 1'b1;
            end
        end
    end
`else
    logic unused_dl;

    assign unused_dl = ^{dl_start, dl_valid, dl_data, dl_end};
    assign we        = 1'b0;
    assign wadr      = '0;
    assign wdat      = '0;
    assign dl_ready  = 1'b0;
    assign dl_busy   = 1'b0;
    assign dl_done   = 1'b0;
    assign dl_words  = '0;
`endif

endmodule

// File: tb/tb_rom_load.sv
// Directed bench for rom_load: three instances (DW 8/16/32, KB=1) share one byte stream; loader checks run when ROM_LOAD_EN is defined.
module tb_rom_load;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dl_start = 1'b0;
    logic        dl_valid = 1'b0;
    logic [7:0]  dl_data = 8'h00;
    logic        dl_end = 1'b0;

    logic [9:0]  a8 = '0;
    logic [8:0]  a16 = '0;
    logic [7:0]  a32 = '0;
    logic [7:0]  q8;
    logic [15:0] q16;
    logic [31:0] q32;
    logic        rdy8, busy8, done8;
    logic        rdy16, busy16, done16;
    logic        rdy32, busy32, done32;
    logic [10:0] words8;
    logic [9:0]  words16;
    logic [8:0]  words32;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    rom_load #(.KB(1), .DW(8)) u8 (
        .clock(clock), .reset(reset), .a(a8), .q(q8),
        .dl_start(dl_start), .dl_valid(dl_valid), .dl_data(dl_data), .dl_end(dl_end),
        .dl_ready(rdy8), .dl_busy(busy8), .dl_done(done8), .dl_words(words8)
    );

    rom_load #(.KB(1), .DW(16)) u16 (
        .clock(clock), .reset(reset), .a(a16), .q(q16),
        .dl_start(dl_start), .dl_valid(dl_valid), .dl_data(dl_data), .dl_end(dl_end),
        .dl_ready(rdy16), .dl_busy(busy16), .dl_done(done16), .dl_words(words16)
    );

    rom_load #(.KB(1), .DW(32)) u32 (
        .clock(clock), .reset(reset), .a(a32), .q(q32),
        .dl_start(dl_start), .dl_valid(dl_valid), .dl_data(dl_data), .dl_end(dl_end),
        .dl_ready(rdy32), .dl_busy(busy32), .dl_done(done32), .dl_words(words32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        dl_valid = 1'b1;
        dl_data  = b;
        tick();
        dl_valid = 1'b0;
    endtask

    task automatic pulse_start();
        dl_start = 1'b1;
        tick();
        dl_start = 1'b0;
    endtask

    task automatic pulse_end();
        dl_end = 1'b1;
        tick();
        dl_end = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("rst q8", q8, 32'hFF);
        check("rst q16", q16, 32'hFFFF);
        check("rst q32", q32, 32'hFFFF_FFFF);
        check("rst rdy8", rdy8, 0);
        check("rst busy8", busy8, 0);
        check("rst done8", done8, 0);
        check("rst words8", words8, 0);
        check("rst words32", words32, 0);

`ifdef ROM_LOAD_EN
        reset = 1'b0;
        tick();

        // DW=16 basic load, observed on all three widths.
        pulse_start();
        check("start rdy16", rdy16, 1);
        check("start busy16", busy16, 1);
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        pulse_end();
        check("w16 words", words16, 2);
        check("w16 done", done16, 1);
        check("w16 rdy after end", rdy16, 0);
        check("w8 words", words8, 4);
        check("w32 words", words32, 1);
        a16 = 9'd0; tick();
        check("w16 word0", q16, 32'h1234);
        a16 = 9'd1; tick();
        check("w16 word1", q16, 32'h5678);
        a32 = 8'd0; tick();
        check("w32 word0", q32, 32'h5678_1234);
        check("q8 at a=0", q8, 32'h34);
        a8 = 10'd2;
        #1;
        check("q8 holds before edge", q8, 32'h34);
        tick();
        check("q8 latency a=2", q8, 32'h78);

        // Five bytes then dl_end: partial words padded with FF.
        pulse_start();
        check("restart clears done", done32, 0);
        for (int i = 1; i <= 5; i++) send(8'(i));
        pulse_end();
        check("w32 partial words", words32, 2);
        check("w16 partial words", words16, 3);
        check("w8 no empty flush", words8, 5);
        a32 = 8'd1; a16 = 9'd2; tick();
        check("w32 word1 padded", q32, 32'hFFFF_FF05);
        check("w16 word2 padded", q16, 32'hFF05);
        a32 = 8'd0; tick();
        check("w32 word0 full", q32, 32'h0403_0201);

        // Write-first: word 3 completed while a16 holds 3.
        a16 = 9'd3;
        pulse_start();
        for (int i = 0; i < 6; i++) send(8'(i));
        send(8'hEF);
        send(8'hBE);
        check("w16 write-first", q16, 32'hBEEF);
        pulse_end();
        check("w16 words after wf", words16, 4);

        // Reset mid-load keeps written words, loses the partial one.
        pulse_start();
        for (int i = 1; i <= 7; i++) send(8'(i * 8'h11));
        check("midload busy", busy16, 1);
        reset = 1'b1;
        tick();
        check("midrst busy16", busy16, 0);
        check("midrst rdy16", rdy16, 0);
        check("midrst words16", words16, 0);
        check("midrst q16", q16, 32'hFFFF);
        reset = 1'b0;
        pulse_start();
        send(8'h99); send(8'h88);
        pulse_end();
        check("reload words16", words16, 1);
        check("reload done16", done16, 1);
        a16 = 9'd1; tick();
        check("old word1 kept", q16, 32'h4433);
        a16 = 9'd2; tick();
        check("old word2 kept", q16, 32'h6655);
        a16 = 9'd3; tick();
        check("partial lost", q16, 32'hBEEF);
        a16 = 9'd0; tick();
        check("new word0", q16, 32'h8899);

        // Overfill u8 (1024 words) with 1100 bytes.
        pulse_start();
        for (int i = 0; i < 1100; i++) begin
            logic [10:0] iv;
            iv = 11'(i);
            send(iv[10:3]);
            if (i == 1022) check("full not yet done", done8, 0);
            if (i == 1023) check("full done", done8, 1);
            if (i == 1030) check("full rdy low", rdy8, 0);
        end
        check("full words8", words8, 11'd1024);
        check("full busy8", busy8, 0);
        a8 = 10'd0; tick();
        check("full mem0 unchanged", q8, 32'h00);
        a8 = 10'd1023; tick();
        check("full mem1023", q8, 32'h7F);
        a8 = 10'd512; tick();
        check("full mem512", q8, 32'h40);
`else
        // Loader absent: dl_* inputs have no effect on the outputs.
        reset = 1'b0;
        pulse_start();
        check("rom rdy8", rdy8, 0);
        check("rom busy16", busy16, 0);
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        pulse_end();
        check("rom done8", done8, 0);
        check("rom done16", done16, 0);
        check("rom done32", done32, 0);
        check("rom words8", words8, 0);
        check("rom words16", words16, 0);
        check("rom words32", words32, 0);
        check("rom rdy32", rdy32, 0);
        check("rom busy32", busy32, 0);
        reset = 1'b1;
        tick();
        check("rom rst q16", q16, 32'hFFFF);
        check("rom rst q32", q32, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
